// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO pointer controller.
// Pointer helpers operate on a wide vector; callers cast to their own width.
package fifo_ctrl_pkg;

    localparam int MAX_PTR_W = 32;

    typedef logic [MAX_PTR_W-1:0] wide_ptr_t;

    // Status flags kept together so reset and next-state values read as one unit.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

    // Number of RAM entries addressed by addr_width bits.
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Binary to reflected gray code.
    function automatic wide_ptr_t bin2gray(input wide_ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Reflected gray code back to binary (for CDC receivers of the gray taps).
    function automatic wide_ptr_t gray2bin(input wide_ptr_t gray);
        wide_ptr_t bin;
        bin = gray;
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_ptr_cntr.sv
// One FIFO pointer: binary counter with an extra wrap bit plus a registered
// gray copy. Instantiated once for the write side and once for the read side.
module fifo_ptr_cntr
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH:0]   bin_next,
    output logic [ADDR_WIDTH:0]   gray
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0] bin;

    // Wraps naturally modulo 2**PTR_W; the MSB tells a full FIFO from an empty one.
    assign bin_next = bin + PTR_W'(inc);
    assign addr     = bin[ADDR_WIDTH-1:0];

    // Binary and gray advance on the same edge so the gray tap never lags the address.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values;
        // a blocking = here would let later statements see the freshly updated value.
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= PTR_W'(bin2gray(wide_ptr_t'(bin_next)));
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer/flag controller for a RAM-based single-clock FIFO.
// Gates requests, drives RAM addresses/strobes, tracks occupancy and flags.
// Optional feature: define FIFO_PTR_CTRL_ERR_EN to add sticky ovf/udf ports.
module fifo_ptr_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray
`ifdef FIFO_PTR_CTRL_ERR_EN
    ,
    output logic                  ovf,
    output logic                  udf
`endif
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    typedef logic [PTR_W-1:0] ptr_t;

    // Thresholds clamped into the representable occupancy range.
    localparam ptr_t AFULL_C  = ptr_t'((AFULL_THRESH > DEPTH) ? DEPTH : AFULL_THRESH);
    localparam ptr_t AEMPTY_C = ptr_t'((AEMPTY_THRESH > DEPTH) ? DEPTH : AEMPTY_THRESH);

    logic        wr_acc;
    logic        rd_acc;
    ptr_t        wr_nxt;
    ptr_t        rd_nxt;
    ptr_t        count_next;
    fifo_flags_t flags_q;
    fifo_flags_t flags_d;

    // Requests are only honoured against the registered flags.
    assign wr_acc = wr_en & ~flags_q.full;
    assign rd_acc = rd_en & ~flags_q.empty;

    assign ram_we = wr_acc;
    assign ram_re = rd_acc;

    fifo_ptr_cntr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (wr_acc),
        .addr     (ram_waddr),
        .bin_next (wr_nxt),
        .gray     (wr_ptr_gray)
    );

    fifo_ptr_cntr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (rd_acc),
        .addr     (ram_raddr),
        .bin_next (rd_nxt),
        .gray     (rd_ptr_gray)
    );

    // Next-state occupancy and flags, derived from the post-edge pointers.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path;
        // assigning defaults first makes a latch impossible.
        count_next           = count + ptr_t'(wr_acc) - ptr_t'(rd_acc);
        flags_d              = FLAGS_RESET;
        flags_d.empty        = (wr_nxt == rd_nxt);
        flags_d.full         = (wr_nxt[ADDR_WIDTH] != rd_nxt[ADDR_WIDTH]) &&
                               (wr_nxt[ADDR_WIDTH-1:0] == rd_nxt[ADDR_WIDTH-1:0]);
        flags_d.almost_full  = (count_next >= AFULL_C);
        flags_d.almost_empty = (count_next <= AEMPTY_C);
    end

    // Occupancy and flag registers; flags reflect an edge one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= '0;
            flags_q <= FLAGS_RESET;
        end else begin
            count   <= count_next;
            flags_q <= flags_d;
        end
    end

    assign full         = flags_q.full;
    assign empty        = flags_q.empty;
    assign almost_full  = flags_q.almost_full;
    assign almost_empty = flags_q.almost_empty;

`ifdef FIFO_PTR_CTRL_ERR_EN
    // Sticky error flags: set by any rejected request, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (wr_en && flags_q.full) begin
                ovf <= 1'b1;
            end
            if (rd_en && flags_q.empty) begin
                udf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl with DEPTH=4. The reference model
// tracks occupancy as an integer and pointers as plain free-running counts.
// Connects ovf/udf when FIFO_PTR_CTRL_ERR_EN is defined.
module tb_fifo_ptr_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AFT   = 3;
    localparam int AET   = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic [AW:0]   wr_ptr_gray;
    logic [AW:0]   rd_ptr_gray;
`ifdef FIFO_PTR_CTRL_ERR_EN
    logic          ovf;
    logic          udf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int occ   = 0;
    int wptr  = 0;
    int rptr  = 0;
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    fifo_ptr_ctrl #(
        .ADDR_WIDTH    (AW),
        .AFULL_THRESH  (AFT),
        .AEMPTY_THRESH (AET)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .ram_we       (ram_we),
        .ram_waddr    (ram_waddr),
        .ram_re       (ram_re),
        .ram_raddr    (ram_raddr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .wr_ptr_gray  (wr_ptr_gray),
        .rd_ptr_gray  (rd_ptr_gray)
`ifdef FIFO_PTR_CTRL_ERR_EN
        ,
        .ovf          (ovf),
        .udf          (udf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [2:0] gray3(input int x);
        logic [2:0] b;
        b = 3'(x);
        return b ^ (b >> 1);
    endfunction

    // {count, full, empty, almost_full, almost_empty, wr_gray, rd_gray, ovf, udf}
    function automatic logic [14:0] exp_state();
        bit eo;
        bit eu;
        eo = 1'b0;
        eu = 1'b0;
`ifdef FIFO_PTR_CTRL_ERR_EN
        eo = m_ovf;
        eu = m_udf;
`endif
        return {3'(occ), (occ == DEPTH), (occ == 0), (occ >= AFT), (occ <= AET),
                gray3(wptr), gray3(rptr), eo, eu};
    endfunction

    function automatic logic [14:0] obs_state();
        logic eo;
        logic eu;
        eo = 1'b0;
        eu = 1'b0;
`ifdef FIFO_PTR_CTRL_ERR_EN
        eo = ovf;
        eu = udf;
`endif
        return {count, full, empty, almost_full, almost_empty,
                wr_ptr_gray, rd_ptr_gray, eo, eu};
    endfunction

    // One clock: apply inputs, capture RAM-side outputs, advance model over the edge.
    task automatic drive(input bit w, input bit r, input bit rs,
                         output logic [5:0] c_obs, output logic [5:0] c_exp);
        bit wa;
        bit ra;
        wr_en = w;
        rd_en = r;
        rst_n = rs;
        #1;
        c_obs = {ram_we, ram_waddr, ram_re, ram_raddr};
        wa    = w && (occ < DEPTH);
        ra    = r && (occ > 0);
        c_exp = {wa, 2'(wptr % DEPTH), ra, 2'(rptr % DEPTH)};
        @(posedge clk);
        if (!rs) begin
            occ   = 0;
            wptr  = 0;
            rptr  = 0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && occ == DEPTH) m_ovf = 1'b1;
            if (r && occ == 0)     m_udf = 1'b1;
            occ  = occ + int'(wa) - int'(ra);
            wptr = (wptr + int'(wa)) % (2 * DEPTH);
            rptr = (rptr + int'(ra)) % (2 * DEPTH);
        end
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] co;
        logic [5:0] ce;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, co, ce);
            n_cmp++;
            if (obs_state() !== exp_state()) begin
                n_bad++;
                $display("FAIL reset_state[%0d]: got %h want %h", i, obs_state(), exp_state());
            end
        end
        n_cmp++;
        if ({count, empty, almost_empty, full, wr_ptr_gray, rd_ptr_gray} !== 12'b000_1_1_0_000_000) begin
            n_bad++;
            $display("FAIL reset_const: got cnt=%b e=%b ae=%b f=%b wg=%b rg=%b",
                     count, empty, almost_empty, full, wr_ptr_gray, rd_ptr_gray);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        logic [5:0] co;
        logic [5:0] ce;
        logic [2:0] gseq [4] = '{3'b001, 3'b011, 3'b010, 3'b110};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, co, ce);
            n_cmp++;
            if (co !== ce) begin
                n_bad++;
                $display("FAIL fill_ram[%0d]: got %b want %b", i, co, ce);
            end
            n_cmp++;
            if (obs_state() !== exp_state()) begin
                n_bad++;
                $display("FAIL fill_state[%0d]: got %h want %h", i, obs_state(), exp_state());
            end
            n_cmp++;
            if (wr_ptr_gray !== gseq[i]) begin
                n_bad++;
                $display("FAIL fill_gray[%0d]: got %b want %b", i, wr_ptr_gray, gseq[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [5:0] co;
        logic [5:0] ce;
        drive(1'b1, 1'b0, 1'b1, co, ce);
        n_cmp++;
        if (co !== ce) begin
            n_bad++;
            $display("FAIL ovf_ram: got %b want %b", co, ce);
        end
        n_cmp++;
        if (obs_state() !== exp_state()) begin
            n_bad++;
            $display("FAIL ovf_state: got %h want %h", obs_state(), exp_state());
        end
    endtask

    task automatic test_simultaneous();
        logic [5:0] co;
        logic [5:0] ce;
        // At full: read only
        drive(1'b1, 1'b1, 1'b1, co, ce);
        n_cmp++;
        if (co !== ce) begin
            n_bad++;
            $display("FAIL simul_full_ram: got %b want %b", co, ce);
        end
        n_cmp++;
        if (obs_state() !== exp_state()) begin
            n_bad++;
            $display("FAIL simul_full_state: got %h want %h", obs_state(), exp_state());
        end
        // Both accepted in the middle: count and flags hold
        drive(1'b1, 1'b1, 1'b1, co, ce);
        n_cmp++;
        if (obs_state() !== exp_state()) begin
            n_bad++;
            $display("FAIL simul_mid_state: got %h want %h", obs_state(), exp_state());
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, co, ce);
        n_cmp++;
        if (obs_state() !== exp_state()) begin
            n_bad++;
            $display("FAIL drain_state: got %h want %h", obs_state(), exp_state());
        end
        // At empty: write only
        drive(1'b1, 1'b1, 1'b1, co, ce);
        n_cmp++;
        if (co !== ce) begin
            n_bad++;
            $display("FAIL simul_empty_ram: got %b want %b", co, ce);
        end
        n_cmp++;
        if (obs_state() !== exp_state()) begin
            n_bad++;
            $display("FAIL simul_empty_state: got %h want %h", obs_state(), exp_state());
        end
    endtask

    task automatic test_wrap();
        logic [5:0] co;
        logic [5:0] ce;
        drive(1'b0, 1'b0, 1'b0, co, ce);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b1, co, ce);
            n_cmp++;
            if (co !== ce) begin
                n_bad++;
                $display("FAIL wrap_wr_ram[%0d]: got %b want %b", i, co, ce);
            end
            drive(1'b0, 1'b1, 1'b1, co, ce);
            n_cmp++;
            if (co !== ce) begin
                n_bad++;
                $display("FAIL wrap_rd_ram[%0d]: got %b want %b", i, co, ce);
            end
            n_cmp++;
            if (obs_state() !== exp_state()) begin
                n_bad++;
                $display("FAIL wrap_state[%0d]: got %h want %h", i, obs_state(), exp_state());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] co;
        logic [5:0] ce;
        drive(1'b1, 1'b0, 1'b1, co, ce);
        drive(1'b1, 1'b0, 1'b1, co, ce);
        drive(1'b0, 1'b1, 1'b0, co, ce);
        n_cmp++;
        if (obs_state() !== exp_state()) begin
            n_bad++;
            $display("FAIL rstmid_state: got %h want %h", obs_state(), exp_state());
        end
        drive(1'b0, 1'b1, 1'b1, co, ce);
        n_cmp++;
        if (co !== ce) begin
            n_bad++;
            $display("FAIL rstmid_rd_ram: got %b want %b", co, ce);
        end
        n_cmp++;
        if (obs_state() !== exp_state()) begin
            n_bad++;
            $display("FAIL rstmid_udf_state: got %h want %h", obs_state(), exp_state());
        end
    endtask

    task automatic test_random();
        logic [5:0] co;
        logic [5:0] ce;
        bit w;
        bit r;
        bit rs;
        for (int i = 0; i < 400; i++) begin
            w  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 45);
            rs = ($urandom_range(0, 49) != 0);
            drive(w, r, rs, co, ce);
            if (rs) begin
                n_cmp++;
                if (co !== ce) begin
                    n_bad++;
                    $display("FAIL rand_ram[%0d]: got %b want %b", i, co, ce);
                end
            end
            n_cmp++;
            if (obs_state() !== exp_state()) begin
                n_bad++;
                $display("FAIL rand_state[%0d]: got %h want %h", i, obs_state(), exp_state());
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_overflow();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
